// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the counter sequencer: FSM state encoding,
// direction encodings and default widths.
package counter_ctrl_pkg;

  localparam int CNT_W_DEF   = 16;
  localparam int PRESC_W_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/cnt_prescaler.sv
// Prescaler for the counter sequencer: counts 0..presc and raises tick on
// the cycle it sits at presc, then wraps. Clear has priority over enable;
// with enable low the count is frozen and no tick is produced.
module cnt_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [PRESC_W-1:0] presc,
  output logic               tick
);

  logic [PRESC_W-1:0] cnt_q;
  logic [PRESC_W-1:0] cnt_d;

  // Next prescaler value and tick decode.
  always_comb begin
    tick  = en & (cnt_q == presc);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + PRESC_W'(1);
    end
  end

  // Prescaler register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Sequencer for a load/clear/up-down counter: loads the reload value,
// enables counting on prescaled ticks, flags the terminal value and either
// reloads (auto mode) or parks in DONE (one-shot mode).
// Optional feature macro: CNT_CTRL_PAUSE_EN adds i_pause, which freezes
// the prescaler and counting while in RUN.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int PRESC_W = PRESC_W_DEF
) (
  input  logic               i_sysclk,
  input  logic               i_sysrst,
`ifdef CNT_CTRL_PAUSE_EN
  input  logic               i_pause,
`endif
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_auto,
  input  logic               i_dir,
  input  logic [CNT_W-1:0]   i_reload,
  input  logic [CNT_W-1:0]   i_term,
  input  logic [PRESC_W-1:0] i_presc,
  input  logic [CNT_W-1:0]   i_cnt_data,
  output logic               o_ld,
  output logic [CNT_W-1:0]   o_ld_data,
  output logic               o_clr,
  output logic               o_cnt_en,
  output logic               o_dir,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_tc
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   reload_q, reload_d;
  logic [CNT_W-1:0]   term_q, term_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               dir_q, dir_d;
  logic               auto_q, auto_d;
  logic               clr_q, clr_d;

  logic run;
  logic at_term;
  logic tc;
  logic presc_en;
  logic presc_clr;
  logic tick;

  assign run     = (state_q == ST_RUN);
  assign at_term = (i_cnt_data == term_q);
  assign tc      = run & at_term;

`ifdef CNT_CTRL_PAUSE_EN
  assign presc_en = ~i_pause;
`else
  assign presc_en = 1'b1;
`endif

  // The prescaler restarts from 0 on every entry into RUN, on stop and
  // at the terminal value.
  assign presc_clr = ~run | i_stop | tc;

  cnt_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_presc (
    .clk   (i_sysclk),
    .rst   (i_sysrst),
    .clr   (presc_clr),
    .en    (presc_en),
    .presc (presc_q),
    .tick  (tick)
  );

  // Next-state and config-latch logic; stop overrides every transition.
  always_comb begin
    state_d  = state_q;
    reload_d = reload_q;
    term_d   = term_q;
    presc_d  = presc_q;
    dir_d    = dir_q;
    auto_d   = auto_q;
    clr_d    = i_stop;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start && !i_stop) begin
          state_d  = ST_LOAD;
          reload_d = i_reload;
          term_d   = i_term;
          presc_d  = i_presc;
          dir_d    = i_dir;
          auto_d   = i_auto;
        end
      end
      ST_LOAD: state_d = ST_RUN;
      ST_RUN: begin
        if (tc) state_d = auto_q ? ST_LOAD : ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (i_stop) state_d = ST_IDLE;
  end

  // FSM, latched configuration and clear strobe registers.
  always_ff @(posedge i_sysclk) begin
    if (i_sysrst) begin
      state_q  <= ST_IDLE;
      reload_q <= '0;
      term_q   <= '0;
      presc_q  <= '0;
      dir_q    <= DIR_DOWN;
      auto_q   <= 1'b0;
      clr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      term_q   <= term_d;
      presc_q  <= presc_d;
      dir_q    <= dir_d;
      auto_q   <= auto_d;
      clr_q    <= clr_d;
    end
  end

  // Output decode from registered state and config.
  always_comb begin
    o_ld      = (state_q == ST_LOAD);
    o_ld_data = reload_q;
    o_clr     = clr_q;
    o_cnt_en  = run & tick & ~at_term;
    o_dir     = dir_q;
    o_busy    = (state_q == ST_LOAD) | run;
    o_done    = (state_q == ST_DONE);
    o_tc      = tc;
  end

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed bench for counter_ctrl, closed-loop with a behavioural 16-bit
// load/clear/up-down counter. Cycle numbers in the tests count from the
// i_start cycle (cycle 0).
module tb_counter_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, auto_m, dir;
  logic [15:0] reload, term;
  logic [7:0]  presc;
  logic        pause;
  logic [15:0] cnt_val;
  logic        o_ld, o_clr, o_cnt_en, o_dir, o_busy, o_done, o_tc;
  logic [15:0] o_ld_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_ctrl #(.CNT_W(16), .PRESC_W(8)) dut (
    .i_sysclk   (clk),
    .i_sysrst   (rst),
`ifdef CNT_CTRL_PAUSE_EN
    .i_pause    (pause),
`endif
    .i_start    (start),
    .i_stop     (stop),
    .i_auto     (auto_m),
    .i_dir      (dir),
    .i_reload   (reload),
    .i_term     (term),
    .i_presc    (presc),
    .i_cnt_data (cnt_val),
    .o_ld       (o_ld),
    .o_ld_data  (o_ld_data),
    .o_clr      (o_clr),
    .o_cnt_en   (o_cnt_en),
    .o_dir      (o_dir),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_tc       (o_tc)
  );

  // Sequenced counter: reset > clear > load > count.
  always_ff @(posedge clk) begin
    if (rst)           cnt_val <= '0;
    else if (o_clr)    cnt_val <= '0;
    else if (o_ld)     cnt_val <= o_ld_data;
    else if (o_cnt_en) cnt_val <= o_dir ? cnt_val + 16'd1 : cnt_val - 16'd1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulses i_start for one cycle with the given config; returns in cycle 1.
  task automatic do_start(input logic [15:0] rl, input logic [15:0] tm,
                          input logic [7:0] ps, input logic d, input logic a);
    reload = rl; term = tm; presc = ps; dir = d; auto_m = a;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({o_ld, o_clr, o_cnt_en, o_dir, o_busy, o_done, o_tc} !== 7'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 0000000",
               {o_ld, o_clr, o_cnt_en, o_dir, o_busy, o_done, o_tc});
    end
    checks++;
    if (o_ld_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_ld_data: got %h expected 0000", o_ld_data);
    end
  endtask

  task automatic test_oneshot_up();
    do_start(16'h0000, 16'h0005, 8'd0, 1'b1, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      checks++;
      if (o_ld !== (c == 1)) begin
        errors++; $display("FAIL t1_ld c=%0d: got %b expected %b", c, o_ld, (c == 1));
      end
      checks++;
      if (o_tc !== (c == 7)) begin
        errors++; $display("FAIL t1_tc c=%0d: got %b expected %b", c, o_tc, (c == 7));
      end
      checks++;
      if (o_done !== (c >= 8)) begin
        errors++; $display("FAIL t1_done c=%0d: got %b expected %b", c, o_done, (c >= 8));
      end
      checks++;
      if (o_busy !== (c <= 7)) begin
        errors++; $display("FAIL t1_busy c=%0d: got %b expected %b", c, o_busy, (c <= 7));
      end
      if (c >= 2 && c <= 7) begin
        checks++;
        if (cnt_val !== 16'(c - 2)) begin
          errors++; $display("FAIL t1_cnt c=%0d: got %h expected %h", c, cnt_val, 16'(c - 2));
        end
      end
      if (c >= 8) begin
        checks++;
        if (cnt_val !== 16'h0005) begin
          errors++; $display("FAIL t1_hold c=%0d: got %h expected 0005", c, cnt_val);
        end
      end
      step();
    end
  endtask

  task automatic test_auto_down();
    do_start(16'h0003, 16'h0000, 8'd1, 1'b0, 1'b1);
    for (int c = 1; c <= 26; c++) begin
      checks++;
      if (o_tc !== (c >= 8 && (c - 8) % 8 == 0)) begin
        errors++;
        $display("FAIL t2_tc c=%0d: got %b expected %b", c, o_tc, (c >= 8 && (c - 8) % 8 == 0));
      end
      checks++;
      if (o_ld !== (c == 1 || (c >= 9 && (c - 9) % 8 == 0))) begin
        errors++;
        $display("FAIL t2_ld c=%0d: got %b expected %b", c, o_ld,
                 (c == 1 || (c >= 9 && (c - 9) % 8 == 0)));
      end
      checks++;
      if (o_dir !== 1'b0 || o_done !== 1'b0) begin
        errors++; $display("FAIL t2_dir_done c=%0d: got %b%b expected 00", c, o_dir, o_done);
      end
      step();
    end
    // Cycle 27 is in RUN; stop ends the auto-reload sequence.
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (o_clr !== 1'b1 || o_busy !== 1'b0) begin
      errors++; $display("FAIL t2_stop: got clr=%b busy=%b expected clr=1 busy=0", o_clr, o_busy);
    end
    step();
    checks++;
    if (o_clr !== 1'b0 || cnt_val !== 16'h0000) begin
      errors++; $display("FAIL t2_cleared: got clr=%b cnt=%h expected clr=0 cnt=0000", o_clr, cnt_val);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_cnt [4];
    exp_cnt[0] = 16'hFFFE; exp_cnt[1] = 16'hFFFF; exp_cnt[2] = 16'h0000; exp_cnt[3] = 16'h0001;
    do_start(16'hFFFE, 16'h0001, 8'd0, 1'b1, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      if (c >= 2 && c <= 5) begin
        checks++;
        if (cnt_val !== exp_cnt[c - 2]) begin
          errors++; $display("FAIL t3_cnt c=%0d: got %h expected %h", c, cnt_val, exp_cnt[c - 2]);
        end
      end
      checks++;
      if (o_tc !== (c == 5)) begin
        errors++; $display("FAIL t3_tc c=%0d: got %b expected %b", c, o_tc, (c == 5));
      end
      step();
    end
  endtask

  task automatic test_stop();
    do_start(16'h0000, 16'h000A, 8'd0, 1'b1, 1'b0);
    step(); step(); step();
    checks++;
    if (cnt_val !== 16'h0002) begin
      errors++; $display("FAIL t4_mid: got %h expected 0002", cnt_val);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    checks++;
    if (o_clr !== 1'b1 || o_busy !== 1'b0 || o_tc !== 1'b0) begin
      errors++; $display("FAIL t4_stop: got clr=%b busy=%b tc=%b expected 1 0 0", o_clr, o_busy, o_tc);
    end
    step();
    checks++;
    if (o_clr !== 1'b0 || cnt_val !== 16'h0000) begin
      errors++; $display("FAIL t4_clr: got clr=%b cnt=%h expected clr=0 cnt=0000", o_clr, cnt_val);
    end
    // Start and stop together in IDLE: clear pulses, no load.
    reload = 16'h0042; term = 16'h0050; start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    checks++;
    if (o_clr !== 1'b1 || o_busy !== 1'b0 || o_ld !== 1'b0) begin
      errors++; $display("FAIL t4_both: got clr=%b busy=%b ld=%b expected 1 0 0", o_clr, o_busy, o_ld);
    end
    step();
    checks++;
    if (o_clr !== 1'b0 || o_busy !== 1'b0 || o_ld !== 1'b0) begin
      errors++; $display("FAIL t4_idle: got clr=%b busy=%b ld=%b expected 0 0 0", o_clr, o_busy, o_ld);
    end
  endtask

  task automatic test_edges();
    // reload == term: terminal in the first RUN cycle.
    do_start(16'h1234, 16'h1234, 8'd5, 1'b1, 1'b0);
    checks++;
    if (o_ld !== 1'b1 || o_tc !== 1'b0) begin
      errors++; $display("FAIL t5_eq_c1: got ld=%b tc=%b expected 1 0", o_ld, o_tc);
    end
    step();
    checks++;
    if (o_tc !== 1'b1 || cnt_val !== 16'h1234 || o_cnt_en !== 1'b0) begin
      errors++; $display("FAIL t5_eq_c2: got tc=%b cnt=%h en=%b expected 1 1234 0", o_tc, cnt_val, o_cnt_en);
    end
    step();
    checks++;
    if (o_done !== 1'b1 || o_tc !== 1'b0) begin
      errors++; $display("FAIL t5_eq_c3: got done=%b tc=%b expected 1 0", o_done, o_tc);
    end
    // i_start during RUN with new config: ignored.
    do_start(16'h0000, 16'h0004, 8'd0, 1'b1, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      checks++;
      if (o_tc !== (c == 6) || o_ld !== (c == 1) || o_done !== (c >= 7)) begin
        errors++;
        $display("FAIL t5_ign c=%0d: got tc=%b ld=%b done=%b expected %b %b %b", c, o_tc, o_ld, o_done,
                 (c == 6), (c == 1), (c >= 7));
      end
      checks++;
      if (o_ld_data !== 16'h0000) begin
        errors++; $display("FAIL t5_ld_data c=%0d: got %h expected 0000", c, o_ld_data);
      end
      if (c == 3) begin
        reload = 16'h0100; term = 16'h0200; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    // Synchronous reset mid-RUN.
    do_start(16'h0055, 16'h00FF, 8'd2, 1'b1, 1'b1);
    step(); step();
    checks++;
    if (o_busy !== 1'b1 || o_dir !== 1'b1) begin
      errors++; $display("FAIL t5_prerst: got busy=%b dir=%b expected 1 1", o_busy, o_dir);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({o_ld, o_clr, o_cnt_en, o_dir, o_busy, o_done, o_tc} !== 7'b0 || o_ld_data !== 16'h0000) begin
      errors++;
      $display("FAIL t5_rst: got flags=%b ld_data=%h expected 0000000 0000",
               {o_ld, o_clr, o_cnt_en, o_dir, o_busy, o_done, o_tc}, o_ld_data);
    end
    rst = 1'b0;
    step();
    checks++;
    if (o_clr !== 1'b0 || o_busy !== 1'b0) begin
      errors++; $display("FAIL t5_postrst: got clr=%b busy=%b expected 0 0", o_clr, o_busy);
    end
  endtask

`ifdef CNT_CTRL_PAUSE_EN
  task automatic test_pause();
    do_start(16'h0000, 16'h0003, 8'd3, 1'b1, 1'b0);
    for (int c = 1; c <= 26; c++) begin
      pause = (c >= 5 && c <= 14);
      #1;
      checks++;
      if (o_tc !== (c == 24)) begin
        errors++; $display("FAIL t6_tc c=%0d: got %b expected %b", c, o_tc, (c == 24));
      end
      if (pause) begin
        checks++;
        if (o_cnt_en !== 1'b0 || o_busy !== 1'b1) begin
          errors++; $display("FAIL t6_paused c=%0d: got en=%b busy=%b expected 0 1", c, o_cnt_en, o_busy);
        end
      end
      step();
    end
    pause = 1'b0;
    checks++;
    if (o_done !== 1'b1 || cnt_val !== 16'h0003) begin
      errors++; $display("FAIL t6_end: got done=%b cnt=%h expected 1 0003", o_done, cnt_val);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; auto_m = 1'b0; dir = 1'b0;
    reload = '0; term = '0; presc = '0; pause = 1'b0;
    step(); step();
    test_reset();
    rst = 1'b0;
    step();
    test_oneshot_up();
    test_auto_down();
    test_wrap();
    test_stop();
    test_edges();
`ifdef CNT_CTRL_PAUSE_EN
    test_pause();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
